// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter feeding one shared 64-bit shifter and a
// one-entry result register with a valid/ready output handshake.
module shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_data,
  input  logic [5:0]  req0_shamt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_data,
  input  logic [5:0]  req1_shamt,
  input  logic [1:0]  req1_op,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_id,
  output logic        res_err
);

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  shamt;
    logic [1:0]  op;
  } req_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic        r_valid;
  logic [63:0] r_data;
  logic        r_id;
  logic        r_err;
  logic        r_prio;   // 0: port 0 wins a tie, 1: port 1 wins a tie

  logic        w_free;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  req_t        w_req;
  logic [63:0] w_shift;
  logic        w_err;

  // Slot is free when empty or being drained this cycle
  assign w_free   = !r_valid || res_ready;
  assign w_gnt0   = rst_n && w_free && req0_valid && (!req1_valid || !r_prio);
  assign w_gnt1   = rst_n && w_free && req1_valid && (!req0_valid ||  r_prio);
  assign w_accept = w_gnt0 || w_gnt1;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    w_req = w_gnt1 ? req_t'{req1_data, req1_shamt, req1_op}
                   : req_t'{req0_data, req0_shamt, req0_op};
  end

  always_comb begin
    w_shift = w_req.data;
    w_err   = 1'b0;
    unique case (w_req.op)
      OP_SLL:  w_shift = w_req.data << w_req.shamt;
      OP_SRL:  w_shift = w_req.data >> w_req.shamt;
      OP_SRA:  w_shift = $unsigned($signed(w_req.data) >>> w_req.shamt);
      default: w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_shift;
        r_id    <= w_gnt1;
        r_err   <= w_err;
        r_prio  <= w_gnt0;
      end else if (res_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign res_err   = r_err;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, shifts, round robin, backpressure.
module tb_shift_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [63:0] req0_data;
  logic [5:0]  req0_shamt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [63:0] req1_data;
  logic [5:0]  req1_shamt;
  logic [1:0]  req1_op;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        res_id, res_err;

  int n_chk = 0;
  int n_bad = 0;

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic [5:0]  sh;
    logic [1:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{64'h1,                  6'd63, 2'b00, 64'h8000000000000000};
    vecs[1] = '{64'h8000000000000000,   6'd63, 2'b01, 64'h1};
    vecs[2] = '{64'h8000000000000000,   6'd63, 2'b10, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{64'hA0A0A0A0A0A0A0A0,   6'd4,  2'b10, 64'hFA0A0A0A0A0A0A0A};
    vecs[4] = '{64'h8000000000000001,   6'd0,  2'b10, 64'h8000000000000001};

    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b1; req0_data = '0; req0_shamt = '0; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = '0; req1_shamt = '0; req1_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_data",  res_data,  0);
    chk("rst_id",    res_id,    0);
    chk("rst_err",   res_err,   0);
    chk("rst_rdy0",  req0_ready, 0);
    chk("rst_rdy1",  req1_ready, 0);

    // First request after reset: SRA by 4
    rst_n = 1'b1; req1_valid = 1'b0;
    req0_data = 64'h8000000000000000; req0_shamt = 6'd4; req0_op = 2'b10;
    #1 chk("sra_rdy0", req0_ready, 1);
    @(posedge clk); #1;
    chk("sra_valid", res_valid, 1);
    chk("sra_data",  res_data,  64'hF800000000000000);
    chk("sra_id",    res_id,    0);
    chk("sra_err",   res_err,   0);

    foreach (vecs[i]) begin
      req0_data = vecs[i].d; req0_shamt = vecs[i].sh; req0_op = vecs[i].op;
      @(posedge clk); #1;
      chk($sformatf("bnd%0d_data", i), res_data, vecs[i].exp);
      chk($sformatf("bnd%0d_valid", i), res_valid, 1);
    end

    // Nothing valid: slot drains
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", res_valid, 0);

    // Illegal op on port 1
    req1_valid = 1'b1; req1_data = 64'h1234; req1_shamt = 6'd5; req1_op = 2'b11;
    @(posedge clk); #1;
    chk("ill_data",  res_data, 64'h1234);
    chk("ill_err",   res_err,  1);
    chk("ill_id",    res_id,   1);
    chk("ill_valid", res_valid, 1);

    // Reset pulse without a clock edge; priority back to port 0
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_err",   res_err,   0);
    rst_n = 1'b1;

    req0_valid = 1'b1; req0_data = 64'h10; req0_shamt = 6'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 64'h10; req1_shamt = 6'd1; req1_op = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr%0d_id", i), res_id, i % 2);
      chk($sformatf("rr%0d_data", i), res_data, (i % 2) ? 64'h8 : 64'h20);
      chk($sformatf("rr%0d_valid", i), res_valid, 1);
    end

    // Backpressure: hold result (id 1, data 0x8), inputs wiggle
    res_ready = 1'b0;
    #1;
    chk("bp_rdy0", req0_ready, 0);
    chk("bp_rdy1", req1_ready, 0);
    for (int i = 0; i < 3; i++) begin
      req0_data = 64'hFFFF + i; req1_data = 64'hEEEE + i;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), res_valid, 1);
      chk($sformatf("bp%0d_id", i),    res_id,    1);
      chk($sformatf("bp%0d_data", i),  res_data,  64'h8);
      chk($sformatf("bp%0d_rdy", i),   {req0_ready, req1_ready}, 0);
    end
    req0_data = 64'h40;
    res_ready = 1'b1;
    #1;
    chk("bp_rel_rdy0", req0_ready, 1);
    chk("bp_rel_rdy1", req1_ready, 0);
    @(posedge clk); #1;
    chk("bp_new_id",   res_id,   0);
    chk("bp_new_data", res_data, 64'h80);

    // Reset while a result is held; next tie goes to port 0 again
    res_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_hold", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", res_valid, 0);
    chk("mid_data",  res_data,  0);
    rst_n = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_id",    res_id,   0);
    chk("mid_rdata", res_data, 64'h80);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters: none; datapath width fixed at 64 bits, shift amount fixed at 6 bits.
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-low, named rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a shift request.
REQ-006 req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
REQ-007 req0_data  input  64  operand.
REQ-008 req0_shamt  input  6  shift amount, 0..63.
REQ-009 req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-010 req1_valid, req1_ready, req1_data, req1_shamt, req1_op SHALL be identical in direction, width and meaning to the port-0 set, for requester 1.
REQ-011 res_valid  output  1  result register holds a valid result.
REQ-012 res_ready  input  1  consumer accepts result this cycle.
REQ-013 res_data  output  64  shifted result.
REQ-014 res_id  output  1  index of the requester that issued the result.
REQ-015 res_err  output  1  high when the issuing op was 11.

Function
REQ-016 The block SHALL contain one shared combinational 64-bit shifter and a one-entry result register.
REQ-017 Transfer rule: a request transfers when reqN_valid && reqN_ready at a rising clk edge; a result transfers when res_valid && res_ready.
REQ-018 Slot free: res_valid==0, or res_valid && res_ready (drain and refill in the same cycle).
REQ-019 Grant: when the slot is free, at most one reqN_ready is high; reqN_ready==0 whenever the slot is not free.
REQ-020 Arbitration: when only one requester is valid, it is granted; when both are valid, the requester holding priority is granted.
REQ-021 Round robin: after a grant to port N, priority passes to the other port; priority is unchanged in cycles without a grant.
REQ-022 reqN_ready MAY depend combinationally on req0_valid, req1_valid and res_ready; res_valid SHALL depend only on registered state.
REQ-023 Latency: a request accepted at edge K SHALL appear on res_* after edge K; throughput is one result per cycle with res_ready held high.
REQ-024 Shift ops: SLL zero-fills low bits; SRL zero-fills high bits; SRA replicates data[63]; shamt 0 returns the operand unchanged.
REQ-025 Illegal op 11: res_data SHALL equal the operand unshifted and res_err SHALL be 1; arbitration and handshake are unaffected.
REQ-026 res_data, res_id and res_err SHALL be held stable while res_valid && !res_ready.
REQ-027 Inputs SHALL be sampled only at the accept edge; later changes to reqN_* SHALL not affect a registered result.
REQ-028 When neither requester is valid and the slot is drained, res_valid SHALL fall to 0 after the edge.

Reset
REQ-029 While rst_n==0: res_valid=0, res_data=0, res_id=0, res_err=0, and priority is set to port 0, all immediately and independent of clk.
REQ-030 While rst_n==0, req0_ready and req1_ready SHALL be 0.
REQ-031 On rst_n deassertion, the first grant with both requesters valid SHALL go to port 0.
REQ-032 A result pending at reset assertion SHALL be discarded, with no partial output.

Verification
REQ-033 After reset, with req0 valid, data 0x8000000000000000, shamt 4, op SRA -> next cycle res_valid=1, res_data=0xF800000000000000, res_id=0, res_err=0.
REQ-034 Both ports continuously valid with res_ready=1 -> grants alternate 0,1,0,1 starting with port 0; one result per cycle.
REQ-035 Backpressure: with res_ready=0 for 3 cycles -> both readies are 0 and res_* are stable; on res_ready=1 -> the result drains and a new request is accepted in the same cycle.
REQ-036 Boundary shifts, shamt 63:
- SLL of 0x1 -> 0x8000000000000000.
- SRL of 0x8000000000000000 -> 0x1.
- SRA of 0x8000000000000000 -> 0xFFFFFFFFFFFFFFFF.
- SRA of 0xA0A0A0A0A0A0A0A0 by 4 -> 0xFA0A0A0A0A0A0A0A.
REQ-037 req1 op 11, data 0x1234 -> res_data=0x1234, res_err=1, res_id=1.
REQ-038 Reset mid-operation: with res_valid=1 held by res_ready=0, rst_n pulsed low -> res_valid=0 without a clock edge; the next simultaneous request is granted to port 0.
